// File: rtl/segment_display_pkg.sv
// Shared types and constants for the two-digit frequency display:
// FSM state encoding, BCD digit width and the seven-segment patterns.
package segment_display_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_segment_decoder.sv
// BCD digit to seven-segment pattern; blank overrides dash, dash overrides digit.
module seven_segment_decoder
  import segment_display_pkg::*;
(
  input  logic [BCD_W-1:0] value,
  input  logic             blank,
  input  logic             dash,
  output logic [6:0]       segments
);

  always_comb begin
    segments = SEG_BLANK;
    if (blank) begin
      segments = SEG_BLANK;
    end else if (dash) begin
      segments = SEG_DASH;
    end else if (value <= 4'd9) begin
      segments = SEG_DIGIT[value];
    end
  end

endmodule

// File: rtl/segment_display_mux.sv
// Binary count (0..127) to two multiplexed seven-segment digits via
// repeated-subtraction BCD conversion, with a one-entry latest-wins load buffer.
module segment_display_mux
  import segment_display_pkg::*;
#(
  parameter int unsigned DIV_BITS      = 8,
  parameter bit          BLANK_LEADING = 1'b0
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       load,
  input  logic [6:0] count,
  output logic [6:0] segments,
  output logic       digit,
  output logic       busy,
  output logic [1:0] dbg_state
);

  state_t             state, state_nxt;
  logic [6:0]         rem, rem_nxt;
  logic [BCD_W-1:0]   tens, tens_nxt;
  logic               ovf_work, ovf_nxt;
  logic               pend_valid, pend_valid_nxt;
  logic [6:0]         pend_count, pend_count_nxt;
  logic [BCD_W-1:0]   disp_tens, disp_tens_nxt;
  logic [BCD_W-1:0]   disp_units, disp_units_nxt;
  logic               disp_ovf, disp_ovf_nxt;
  logic               disp_valid, disp_valid_nxt;
  logic               start;
  logic [6:0]         start_count;
  logic [DIV_BITS-1:0] presc;
  logic [BCD_W-1:0]   sel_value;
  logic               sel_blank;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A fresh load or the held pending value is launched from one shared
  // start path, used by both IDLE and COMMIT; the live load wins.
  always_comb begin
    state_nxt      = state;
    rem_nxt        = rem;
    tens_nxt       = tens;
    ovf_nxt        = ovf_work;
    pend_valid_nxt = pend_valid;
    pend_count_nxt = pend_count;
    disp_tens_nxt  = disp_tens;
    disp_units_nxt = disp_units;
    disp_ovf_nxt   = disp_ovf;
    disp_valid_nxt = disp_valid;
    start          = 1'b0;
    start_count    = count;

    case (state)
      ST_IDLE: begin
        if (load) begin
          start = 1'b1;
        end else if (pend_valid) begin
          start       = 1'b1;
          start_count = pend_count;
        end
      end
      ST_CONVERT: begin
        if (load) begin
          pend_valid_nxt = 1'b1;
          pend_count_nxt = count;
        end
        if (rem >= 7'd10) begin
          rem_nxt  = rem - 7'd10;
          tens_nxt = tens + 4'd1;
        end else begin
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        disp_tens_nxt  = tens;
        disp_units_nxt = rem[BCD_W-1:0];
        disp_ovf_nxt   = ovf_work;
        disp_valid_nxt = 1'b1;
        state_nxt      = ST_IDLE;
        if (load) begin
          start = 1'b1;
        end else if (pend_valid) begin
          start       = 1'b1;
          start_count = pend_count;
        end
      end
      default: begin
        if (load) begin
          pend_valid_nxt = 1'b1;
          pend_count_nxt = count;
        end
        state_nxt = ST_IDLE;
      end
    endcase

    if (start) begin
      pend_valid_nxt = 1'b0;
      tens_nxt       = '0;
      if (start_count > 7'd99) begin
        ovf_nxt   = 1'b1;
        state_nxt = ST_COMMIT;
      end else begin
        ovf_nxt   = 1'b0;
        rem_nxt   = start_count;
        state_nxt = ST_CONVERT;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rem        <= '0;
      tens       <= '0;
      ovf_work   <= 1'b0;
      pend_valid <= 1'b0;
      pend_count <= '0;
      disp_tens  <= '0;
      disp_units <= '0;
      disp_ovf   <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      rem        <= rem_nxt;
      tens       <= tens_nxt;
      ovf_work   <= ovf_nxt;
      pend_valid <= pend_valid_nxt;
      pend_count <= pend_count_nxt;
      disp_tens  <= disp_tens_nxt;
      disp_units <= disp_units_nxt;
      disp_ovf   <= disp_ovf_nxt;
      disp_valid <= disp_valid_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      presc <= '0;
      digit <= 1'b0;
    end else begin
      presc <= presc + DIV_BITS'(1);
      if (presc == '1) begin
        digit <= ~digit;
      end
    end
  end

  always_comb begin
    sel_value = digit ? disp_tens : disp_units;
    sel_blank = !disp_valid ||
                (BLANK_LEADING && digit && (disp_tens == '0) && !disp_ovf);
  end

  seven_segment_decoder u_decoder (
    .value    (sel_value),
    .blank    (sel_blank),
    .dash     (disp_ovf),
    .segments (segments)
  );

  assign busy      = (state != ST_IDLE) || pend_valid;
  assign dbg_state = state;

endmodule

// File: tb/tb_segment_display_mux.sv
// Directed bench: two instances (fast prescaler, leading blank off/on)
// driven from shared stimulus, checked against hand-computed patterns.
module tb_segment_display_mux;

  logic       clk = 1'b0;
  logic       resetb;
  logic       load;
  logic [6:0] count;
  logic [6:0] segs_a, segs_b;
  logic       digit_a, digit_b, busy_a, busy_b;
  logic [1:0] st_a, st_b;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  segment_display_mux #(.DIV_BITS(2), .BLANK_LEADING(1'b0)) dut_a (
    .clk(clk), .resetb(resetb), .load(load), .count(count),
    .segments(segs_a), .digit(digit_a), .busy(busy_a), .dbg_state(st_a)
  );

  segment_display_mux #(.DIV_BITS(2), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .resetb(resetb), .load(load), .count(count),
    .segments(segs_b), .digit(digit_b), .busy(busy_b), .dbg_state(st_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    load   = 1'b0;
    count  = '0;
    step();
    step();
    resetb = 1'b1;
  endtask

  task automatic read_digits(output logic [6:0] ta, output logic [6:0] ua,
                             output logic [6:0] tb, output logic [6:0] ub,
                             output bit ok);
    int cnt;
    ok  = 1'b1;
    cnt = 0;
    while (digit_a !== 1'b1 && cnt < 16) begin step(); cnt++; end
    if (digit_a !== 1'b1) ok = 1'b0;
    ta  = segs_a;
    tb  = segs_b;
    cnt = 0;
    while (digit_a !== 1'b0 && cnt < 16) begin step(); cnt++; end
    if (digit_a !== 1'b0) ok = 1'b0;
    ua = segs_a;
    ub = segs_b;
  endtask

  task automatic test_reset();
    resetb = 1'b0; load = 1'b0; count = '0;
    step(); step();
    n_checks++; if (segs_a !== 7'h00) $display("FAIL rst_segs_a: got %h want %h", segs_a, 7'h00); else n_pass++;
    n_checks++; if (segs_b !== 7'h00) $display("FAIL rst_segs_b: got %h want %h", segs_b, 7'h00); else n_pass++;
    n_checks++; if (st_a !== 2'd0) $display("FAIL rst_state: got %0d want 0", st_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_a); else n_pass++;
    n_checks++; if (digit_a !== 1'b0) $display("FAIL rst_digit: got %b want 0", digit_a); else n_pass++;
    resetb = 1'b1;
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (segs_a !== 7'h00) $display("FAIL rst_blank_hold: got %h want %h", segs_a, 7'h00); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", busy_a); else n_pass++;
  endtask

  task automatic test_load_42();
    logic [6:0] ta, ua, tb, ub;
    logic [6:0] exp;
    bit ok;
    do_reset();
    load = 1'b1; count = 7'd42;
    step();
    load = 1'b0;
    n_checks++; if (st_a !== 2'd1) $display("FAIL l42_state_k: got %0d want 1", st_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b1) $display("FAIL l42_busy_k: got %b want 1", busy_a); else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_checks++; if (busy_a !== 1'b1) $display("FAIL l42_busy: edge k+%0d got %b want 1", i, busy_a); else n_pass++;
    end
    n_checks++; if (st_a !== 2'd2) $display("FAIL l42_commit_state: got %0d want 2", st_a); else n_pass++;
    n_checks++; if (segs_a !== 7'h00) $display("FAIL l42_no_partial: got %h want %h", segs_a, 7'h00); else n_pass++;
    step();
    n_checks++; if (busy_a !== 1'b0) $display("FAIL l42_busy_done: got %b want 0", busy_a); else n_pass++;
    n_checks++; if (st_a !== 2'd0) $display("FAIL l42_idle: got %0d want 0", st_a); else n_pass++;
    exp = digit_a ? 7'h66 : 7'h5B;
    n_checks++; if (segs_a !== exp) $display("FAIL l42_visible: got %h want %h", segs_a, exp); else n_pass++;
    read_digits(ta, ua, tb, ub, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL l42_digit_timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if (ta !== 7'h66) $display("FAIL l42_tens: got %h want %h", ta, 7'h66); else n_pass++;
    n_checks++; if (ua !== 7'h5B) $display("FAIL l42_units: got %h want %h", ua, 7'h5B); else n_pass++;
    n_checks++; if (tb !== 7'h66) $display("FAIL l42_tens_b: got %h want %h", tb, 7'h66); else n_pass++;
  endtask

  task automatic test_blank_leading();
    logic [6:0] ta, ua, tb, ub;
    logic [6:0] exp;
    bit ok;
    do_reset();
    load = 1'b1; count = 7'd7;
    step();
    load = 1'b0;
    step();
    n_checks++; if (st_b !== 2'd2) $display("FAIL bl_commit_state: got %0d want 2", st_b); else n_pass++;
    n_checks++; if (segs_b !== 7'h00) $display("FAIL bl_pre_commit: got %h want %h", segs_b, 7'h00); else n_pass++;
    step();
    exp = digit_b ? 7'h00 : 7'h07;
    n_checks++; if (segs_b !== exp) $display("FAIL bl_visible: got %h want %h", segs_b, exp); else n_pass++;
    read_digits(ta, ua, tb, ub, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL bl_digit_timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if (tb !== 7'h00) $display("FAIL bl_tens_b: got %h want %h", tb, 7'h00); else n_pass++;
    n_checks++; if (ub !== 7'h07) $display("FAIL bl_units_b: got %h want %h", ub, 7'h07); else n_pass++;
    n_checks++; if (ta !== 7'h3F) $display("FAIL bl_tens_a: got %h want %h", ta, 7'h3F); else n_pass++;
    n_checks++; if (ua !== 7'h07) $display("FAIL bl_units_a: got %h want %h", ua, 7'h07); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [6:0] ta, ua, tb, ub;
    logic [6:0] exp;
    bit ok;
    do_reset();
    load = 1'b1; count = 7'd100;
    step();
    load = 1'b0;
    n_checks++; if (st_a !== 2'd2) $display("FAIL ovf100_direct_commit: got %0d want 2", st_a); else n_pass++;
    step();
    n_checks++; if (segs_a !== 7'h40) $display("FAIL ovf100_dash: got %h want %h", segs_a, 7'h40); else n_pass++;
    load = 1'b1; count = 7'd0;
    step();
    load = 1'b0;
    step(); step();
    n_checks++; if (segs_a !== 7'h3F) $display("FAIL zero_a: got %h want %h", segs_a, 7'h3F); else n_pass++;
    exp = digit_b ? 7'h00 : 7'h3F;
    n_checks++; if (segs_b !== exp) $display("FAIL zero_b: got %h want %h", segs_b, exp); else n_pass++;
    load = 1'b1; count = 7'd120;
    step();
    load = 1'b0;
    step();
    n_checks++; if (busy_a !== 1'b0) $display("FAIL ovf120_busy: got %b want 0", busy_a); else n_pass++;
    n_checks++; if (st_a !== 2'd0) $display("FAIL ovf120_state: got %0d want 0", st_a); else n_pass++;
    n_checks++; if (segs_a !== 7'h40) $display("FAIL ovf120_dash_a: got %h want %h", segs_a, 7'h40); else n_pass++;
    n_checks++; if (segs_b !== 7'h40) $display("FAIL ovf120_dash_b: got %h want %h", segs_b, 7'h40); else n_pass++;
    read_digits(ta, ua, tb, ub, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL ovf_digit_timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if ({ta, ua} !== {7'h40, 7'h40}) $display("FAIL ovf_both_a: got %h/%h want 40/40", ta, ua); else n_pass++;
    n_checks++; if ({tb, ub} !== {7'h40, 7'h40}) $display("FAIL ovf_both_b: got %h/%h want 40/40", tb, ub); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] ta, ua, tb, ub;
    logic [6:0] exp;
    bit ok;
    do_reset();
    load = 1'b1; count = 7'd99;
    step();
    count = 7'd5;
    step();
    load = 1'b0;
    step();
    load = 1'b1; count = 7'd13;
    step();
    load = 1'b0;
    n_checks++; if (busy_a !== 1'b1) $display("FAIL b2b_busy_k3: got %b want 1", busy_a); else n_pass++;
    for (int i = 4; i <= 10; i++) begin
      step();
      n_checks++; if (busy_a !== 1'b1) $display("FAIL b2b_busy: edge k+%0d got %b want 1", i, busy_a); else n_pass++;
    end
    n_checks++; if (st_a !== 2'd2) $display("FAIL b2b_commit99: got %0d want 2", st_a); else n_pass++;
    step();
    n_checks++; if (segs_a !== 7'h6F) $display("FAIL b2b_show99: got %h want %h", segs_a, 7'h6F); else n_pass++;
    n_checks++; if (st_a !== 2'd1) $display("FAIL b2b_pending_start: got %0d want 1", st_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b1) $display("FAIL b2b_busy_k11: got %b want 1", busy_a); else n_pass++;
    step();
    n_checks++; if (segs_a !== 7'h6F) $display("FAIL b2b_hold99_k12: got %h want %h", segs_a, 7'h6F); else n_pass++;
    step();
    n_checks++; if (segs_a !== 7'h6F) $display("FAIL b2b_hold99_k13: got %h want %h", segs_a, 7'h6F); else n_pass++;
    n_checks++; if (st_a !== 2'd2) $display("FAIL b2b_commit13: got %0d want 2", st_a); else n_pass++;
    step();
    n_checks++; if (busy_a !== 1'b0) $display("FAIL b2b_busy_done: got %b want 0", busy_a); else n_pass++;
    exp = digit_a ? 7'h06 : 7'h4F;
    n_checks++; if (segs_a !== exp) $display("FAIL b2b_show13: got %h want %h", segs_a, exp); else n_pass++;
    read_digits(ta, ua, tb, ub, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL b2b_digit_timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if ({ta, ua} !== {7'h06, 7'h4F}) $display("FAIL b2b_final13: got %h/%h want 06/4f", ta, ua); else n_pass++;
  endtask

  task automatic test_prescaler();
    logic exp_d;
    logic [6:0] exp;
    do_reset();
    load = 1'b1; count = 7'd37;
    step();
    load = 1'b0;
    n_checks++; if (digit_a !== 1'b0) $display("FAIL presc_digit: edge 1 got %b want 0", digit_a); else n_pass++;
    for (int j = 2; j <= 16; j++) begin
      step();
      exp_d = ((j / 4) % 2) == 1;
      n_checks++; if (digit_a !== exp_d) $display("FAIL presc_digit: edge %0d got %b want %b", j, digit_a, exp_d); else n_pass++;
      if (j >= 6) begin
        exp = exp_d ? 7'h4F : 7'h07;
        n_checks++; if (segs_a !== exp) $display("FAIL presc_follow: edge %0d got %h want %h", j, segs_a, exp); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_convert();
    logic [6:0] exp;
    do_reset();
    load = 1'b1; count = 7'd87;
    step();
    count = 7'd55;
    step();
    load = 1'b0;
    step();
    n_checks++; if (st_a !== 2'd1) $display("FAIL rmc_converting: got %0d want 1", st_a); else n_pass++;
    resetb = 1'b0;
    #1;
    n_checks++; if (segs_a !== 7'h00) $display("FAIL rmc_segs: got %h want %h", segs_a, 7'h00); else n_pass++;
    n_checks++; if (st_a !== 2'd0) $display("FAIL rmc_state: got %0d want 0", st_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL rmc_busy: got %b want 0", busy_a); else n_pass++;
    n_checks++; if (digit_a !== 1'b0) $display("FAIL rmc_digit: got %b want 0", digit_a); else n_pass++;
    step();
    resetb = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++; if ({busy_a, segs_a} !== 8'h00) $display("FAIL rmc_stale: cycle %0d got busy %b segs %h want 0/00", i, busy_a, segs_a); else n_pass++;
    end
    load = 1'b1; count = 7'd3;
    step();
    load = 1'b0;
    n_checks++; if (st_a !== 2'd1) $display("FAIL rmc_fresh_start: got %0d want 1", st_a); else n_pass++;
    step(); step();
    exp = digit_a ? 7'h3F : 7'h4F;
    n_checks++; if (segs_a !== exp) $display("FAIL rmc_show3: got %h want %h", segs_a, exp); else n_pass++;
    step();
    n_checks++; if ({busy_a, st_a} !== 3'b000) $display("FAIL rmc_no_pending: got busy %b state %0d want 0/0", busy_a, st_a); else n_pass++;
  endtask

  initial begin
    resetb = 1'b0;
    load   = 1'b0;
    count  = '0;
    test_reset();
    test_load_42();
    test_blank_leading();
    test_overflow();
    test_back_to_back();
    test_prescaler();
    test_reset_mid_convert();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/segment_display_mux.md
SEGMENT_DISPLAY_MUX -- requirements
Module: segment_display_mux

Interface
REQ-001 Parameter DIV_BITS, default 8: width of the digit-multiplex prescaler; each digit is shown for 2^DIV_BITS clocks.
REQ-002 Parameter BLANK_LEADING, default 0: when 1, a tens digit of zero shows blank.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 resetb  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  one-cycle strobe; count is valid when high.
REQ-006 count  input  7  edge count from the frequency counter (0..127).
REQ-007 segments  output  7  {g,f,e,d,c,b,a}, active high, for the digit selected by digit.
REQ-008 digit  output  1  1 = tens display driven, 0 = units display driven.
REQ-009 busy  output  1  high while converting or while a pending load is held.
REQ-010 dbg_state  output  2  current FSM state encoding.

Function
REQ-011 FSM states SHALL be IDLE=0, CONVERT=1, COMMIT=2; encoding 3 is unreachable and returns to IDLE.
REQ-012 IDLE, load=1, count<=99: rem<=count, tens<=0, go to CONVERT.
REQ-013 IDLE, load=1, count>99: overflow flag set, go directly to COMMIT.
REQ-014 CONVERT: rem>=10 -> rem<=rem-10, tens<=tens+1, stay; rem<10 -> go to COMMIT.
REQ-015 COMMIT: display registers <= {tens, rem} (or overflow); digit values are 4-bit; go to IDLE, or consume pending per REQ-017.
REQ-016 Latency: load sampled at edge k with value v<=99 -> new display visible after edge k+floor(v/10)+2; v>99 -> after edge k+1.
REQ-017 Load while state != IDLE is stored in a one-entry pending register; a later load overwrites it (latest wins); COMMIT with pending valid starts that value as in REQ-012/013 and clears pending.
REQ-018 Display registers update only in COMMIT; segments never show a partially converted value.
REQ-019 Decode: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F; overflow = 0x40 (dash) on both digits; blank = 0x00.
REQ-020 BLANK_LEADING=1 and tens=0 (not overflow): tens display shows 0x00.
REQ-021 Prescaler free-runs modulo 2^DIV_BITS; digit toggles on the edge where the prescaler wraps from all-ones to zero.
REQ-022 segments is a combinational decode of the display register selected by the registered digit; no extra latency.
REQ-023 busy = (state != IDLE) | pending_valid.

Reset
REQ-024 resetb low asynchronously forces: state IDLE, pending cleared, prescaler 0, digit 0, busy 0, overflow 0, both display registers blank (segments 0x00).
REQ-025 Reset mid-CONVERT discards the conversion and any pending value; the first load after release is handled from IDLE.
REQ-026 Display stays blank after reset until the first COMMIT.

Structure
REQ-027 Package segment_display_pkg SHALL hold the state enum, SEG_DIGIT table, SEG_DASH, SEG_BLANK and the BCD-digit width constant.
REQ-028 Sub-module seven_segment_decoder (4-bit digit plus blank/dash controls -> 7-bit segments) SHALL be instantiated once, after the digit select mux.

Verification
REQ-029 Reset, load 42 at edge k -> busy 1 through edge k+5; after edge k+6 tens=0x66, units=0x5B.
REQ-030 BLANK_LEADING=1, load 7 -> tens=0x00, units=0x07 after edge k+2.
REQ-031 Load 120 -> both digits 0x40 after edge k+1; busy low after edge k+1.
REQ-032 Load 99, then 5 and 13 while busy -> display 99 (0x6F/0x6F), then 13 (0x06/0x4F); 5 never displayed; busy stays high throughout.
REQ-033 DIV_BITS=2 -> digit toggles every 4 clocks from reset release; segments follow digit in the same cycle.
REQ-034 resetb pulsed low during CONVERT of 87 -> segments 0x00, dbg_state 0, busy 0 immediately; no stale value committed.
